serial_full_subtractor: RTL and testbench

//   Bit-serial N-bit subtractor: computes diff = a - b, LSB first, one full-subtractor step per clock.
//   A single borrow flip-flop carries the borrow between steps.

---
 rtl/serial_full_subtractor.sv | 145 ++++++++++++++
 tb/tb_serial_full_subtractor.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_full_subtractor.sv
// Bit-serial a-b, LSB first, one full-subtractor step per clock with a single borrow flop.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
module serial_full_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             bw_q, bw_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             d_bit;
`ifdef SERIAL_SUB_OVF_EN
    // Operand MSBs are kept separately because the operand regs shift them away.
    logic             am_q, am_d;
    logic             bm_q, bm_d;
    logic             ovf_q, ovf_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            bw_q     <= 1'b0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            am_q     <= 1'b0;
            bm_q     <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            bw_q     <= bw_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
            am_q     <= am_d;
            bm_q     <= bm_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        bw_d     = bw_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        d_bit    = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        am_d     = am_q;
        bm_d     = bm_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    res_d   = '0;
                    bw_d    = 1'b0;
                    cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
                    am_d    = a[WIDTH-1];
                    bm_d    = b[WIDTH-1];
`endif
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                d_bit = a_q[0] ^ b_q[0] ^ bw_q;
                bw_d  = (~a_q[0] & b_q[0]) | (~a_q[0] & bw_q) | (b_q[0] & bw_q);
                res_d = {d_bit, res_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                diff_d   = res_q;
                borrow_d = bw_q;
                done_d   = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                ovf_d    = (am_q ^ bm_q) & (am_q ^ res_q[WIDTH-1]);
`endif
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign overflow   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_full_subtractor.sv
// Bench for serial_full_subtractor: 8-bit directed/random runs plus an exhaustive 3-bit sweep.
module tb_serial_full_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, bo8;
    logic [7:0] diff8;

    logic       start3 = 1'b0;
    logic [2:0] a3 = '0, b3 = '0;
    logic       busy3, done3, bo3;
    logic [2:0] diff3;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf8, ovf3;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_full_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
`ifdef SERIAL_SUB_OVF_EN
        , .overflow(ovf8)
`endif
    );

    serial_full_subtractor #(.WIDTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3),
        .busy(busy3), .done(done3), .diff(diff3), .borrow_out(bo3)
`ifdef SERIAL_SUB_OVF_EN
        , .overflow(ovf3)
`endif
    );

    // Drives one 8-bit operation and reports what was observed; optional start pulses while busy.
    task automatic run_op8(input logic [7:0] av, input logic [7:0] bv, input bit ign,
                           output int cyc, output int bcnt, output bit stable);
        logic [7:0] prev;
        prev   = diff8;
        cyc    = 0;
        bcnt   = 0;
        stable = 1'b1;
        @(negedge clk);
        start8 = 1'b1;
        a8 = av;
        b8 = bv;
        while (cyc <= 40) begin
            @(negedge clk);
            cyc++;
            if (busy8) bcnt++;
            if (done8) begin
                start8 = 1'b0;
                break;
            end
            if (diff8 !== prev) stable = 1'b0;
            start8 = ign && (cyc == 4 || cyc == 9);
            if (start8) begin
                a8 = 8'hFF;
                b8 = 8'h01;
            end else begin
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end
        end
        start8 = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++;
        if ({busy8, done8, diff8, bo8} !== 11'd0) begin
            bad++;
            $display("FAIL reset8 got busy=%b done=%b diff=%h bo=%b want all 0", busy8, done8, diff8, bo8);
        end
        total++;
        if ({busy3, done3, diff3, bo3} !== 6'd0) begin
            bad++;
            $display("FAIL reset3 got busy=%b done=%b diff=%h bo=%b want all 0", busy3, done3, diff3, bo3);
        end
`ifdef SERIAL_SUB_OVF_EN
        total++;
        if (ovf8 !== 1'b0) begin
            bad++;
            $display("FAIL reset_ovf got %b want 0", ovf8);
        end
`endif
        rst_n = 1'b1;
        $display("reset checked");
    endtask

    task automatic test_directed;
        logic [7:0] ta[5] = '{8'd200, 8'd5,  8'h55, 8'hA7, 8'h00};
        logic [7:0] tb[5] = '{8'd55,  8'd10, 8'h55, 8'h00, 8'h01};
        int cyc, bcnt;
        bit stable;
        for (int i = 0; i < 5; i++) begin
            run_op8(ta[i], tb[i], 1'b0, cyc, bcnt, stable);
            total++;
            if (cyc != 10 || bcnt != 9 || !stable) begin
                bad++;
                $display("FAIL timing%0d got cyc=%0d busy=%0d stable=%0b want 10/9/1", i, cyc, bcnt, stable);
            end
            total++;
            if (diff8 !== 8'(ta[i] - tb[i]) || bo8 !== (ta[i] < tb[i])) begin
                bad++;
                $display("FAIL directed%0d a=%h b=%h got diff=%h bo=%b want %h %b", i, ta[i], tb[i],
                         diff8, bo8, 8'(ta[i] - tb[i]), ta[i] < tb[i]);
            end
            $display("op a=%h b=%h diff=%h bo=%b cyc=%0d", ta[i], tb[i], diff8, bo8, cyc);
        end
    endtask

    task automatic test_ignore_start;
        int cyc, bcnt, extra_done, extra_busy;
        bit stable;
        run_op8(8'h3C, 8'h0F, 1'b1, cyc, bcnt, stable);
        extra_done = 0;
        extra_busy = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done8) extra_done++;
            if (busy8) extra_busy++;
        end
        total++;
        if (cyc != 10 || diff8 !== 8'h2D || bo8 !== 1'b0) begin
            bad++;
            $display("FAIL ignore_result got cyc=%0d diff=%h bo=%b want 10 2d 0", cyc, diff8, bo8);
        end
        total++;
        if (extra_done != 0 || extra_busy != 0) begin
            bad++;
            $display("FAIL ignore_queue got done=%0d busy=%0d want 0 0", extra_done, extra_busy);
        end
        $display("ignore-start run diff=%h extra_done=%0d", diff8, extra_done);
    endtask

    task automatic test_reset_mid;
        int cyc, bcnt;
        bit stable;
        @(negedge clk);
        start8 = 1'b1;
        a8 = 8'h80;
        b8 = 8'h01;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy8, done8, diff8, bo8} !== 11'd0) begin
            bad++;
            $display("FAIL reset_mid got busy=%b done=%b diff=%h bo=%b want all 0", busy8, done8, diff8, bo8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op8(8'h80, 8'h01, 1'b0, cyc, bcnt, stable);
        total++;
        if (cyc != 10 || diff8 !== 8'h7F || bo8 !== 1'b0) begin
            bad++;
            $display("FAIL after_reset got cyc=%0d diff=%h bo=%b want 10 7f 0", cyc, diff8, bo8);
        end
`ifdef SERIAL_SUB_OVF_EN
        total++;
        if (ovf8 !== 1'b1) begin
            bad++;
            $display("FAIL ovf_80_01 got %b want 1", ovf8);
        end
        run_op8(8'h10, 8'h01, 1'b0, cyc, bcnt, stable);
        total++;
        if (diff8 !== 8'h0F || ovf8 !== 1'b0) begin
            bad++;
            $display("FAIL ovf_10_01 got diff=%h ovf=%b want 0f 0", diff8, ovf8);
        end
`endif
        $display("reset-mid recovery diff=%h", diff8);
    endtask

    task automatic test_random;
        logic [7:0] av, bv;
        int cyc, bcnt, sd;
        bit stable;
        for (int i = 0; i < 40; i++) begin
            av = 8'($urandom);
            bv = (i % 8 == 0) ? av : 8'($urandom);
            run_op8(av, bv, 1'b0, cyc, bcnt, stable);
            sd = int'($signed(av)) - int'($signed(bv));
            total++;
            if (cyc != 10 || !stable || diff8 !== 8'((int'(av) - int'(bv) + 256) % 256)
                || bo8 !== (av < bv)) begin
                bad++;
                $display("FAIL random%0d a=%h b=%h got diff=%h bo=%b cyc=%0d", i, av, bv, diff8, bo8, cyc);
            end
`ifdef SERIAL_SUB_OVF_EN
            total++;
            if (ovf8 !== (sd > 127 || sd < -128)) begin
                bad++;
                $display("FAIL random_ovf%0d a=%h b=%h got %b want %b", i, av, bv, ovf8, sd > 127 || sd < -128);
            end
`endif
            $display("rand a=%h b=%h diff=%h bo=%b", av, bv, diff8, bo8);
        end
    endtask

    task automatic test_back_to_back_w3;
        int cyc, sd;
        for (int ai = 0; ai < 8; ai++) begin
            for (int bi = 0; bi < 8; bi++) begin
                start3 = 1'b1;
                a3 = 3'(ai);
                b3 = 3'(bi);
                @(negedge clk);
                start3 = 1'b0;
                cyc = 1;
                while (!done3 && cyc < 20) begin
                    @(negedge clk);
                    cyc++;
                end
                total++;
                if (!done3 || cyc != 5 || diff3 !== 3'((ai - bi) & 7) || bo3 !== (ai < bi)) begin
                    bad++;
                    $display("FAIL sweep a=%0d b=%0d got diff=%0d bo=%b cyc=%0d want %0d %b 5",
                             ai, bi, diff3, bo3, cyc, (ai - bi) & 7, ai < bi);
                end
`ifdef SERIAL_SUB_OVF_EN
                sd = (ai > 3 ? ai - 8 : ai) - (bi > 3 ? bi - 8 : bi);
                total++;
                if (ovf3 !== (sd > 3 || sd < -4)) begin
                    bad++;
                    $display("FAIL sweep_ovf a=%0d b=%0d got %b", ai, bi, ovf3);
                end
`else
                sd = 0;
`endif
                $display("w3 a=%0d b=%0d diff=%0d bo=%b", ai, bi, diff3, bo3);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid();
        test_random();
        test_back_to_back_w3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
